// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage SRAM access controller with wait states and pipeline freeze
// Optional misaligned-access trap is compiled in with MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int WAIT_STATES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       ST_val_in,
    input  logic [3:0]        Dest_in,

    output logic              freeze,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we,
    output logic              sram_rd,
    input  logic [31:0]       sram_rdata,

    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic [31:0]       ALU_result,
    output logic [31:0]       MEM_result,
    output logic [3:0]        Dest,

    output logic              align_err
);

    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);
    localparam logic [31:0] BASE    = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic [31:0]         hold;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                req;
    logic                misalign;
    logic [31:0]         offset;
    logic [ADDR_W-1:0]   addr_in;

    assign req     = MEM_R_EN_in | MEM_W_EN_in;
    assign offset  = ALU_result_in - BASE;
    assign addr_in = ADDR_W'(offset >> 2);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = req && (ALU_result_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx = misalign ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes are gated by rst so an aborted access releases the SRAM immediately.
    always_comb begin
        freeze  = 1'b0;
        sram_we = 1'b0;
        sram_rd = 1'b0;
        case (state)
            S_IDLE:   freeze = req;
            S_ACCESS: begin
                freeze  = 1'b1;
                sram_we = wr_q & ~rst;
                sram_rd = ~wr_q & ~rst;
            end
            default: ;
        endcase
    end

    // Address and data are latched at access start so the SRAM sees stable values.
    assign sram_addr  = (state == S_ACCESS) ? addr_q  : addr_in;
    assign sram_wdata = (state == S_ACCESS) ? wdata_q : ST_val_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            hold    <= 32'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cnt     <= WS_INIT;
                        wr_q    <= MEM_W_EN_in;
                        addr_q  <= addr_in;
                        wdata_q <= ST_val_in;
                        if (misalign) begin
                            hold <= 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!wr_q) begin
                        hold <= sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM/WB register: a frozen cycle inserts a bubble by clearing WB_en only.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_en      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            ALU_result <= 32'd0;
            MEM_result <= 32'd0;
            Dest       <= 4'd0;
        end else if (freeze) begin
            WB_en      <= 1'b0;
        end else begin
            WB_en      <= WB_en_in;
            MEM_R_EN   <= MEM_R_EN_in;
            ALU_result <= ALU_result_in;
            MEM_result <= hold;
            Dest       <= Dest_in;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (state == S_IDLE && misalign) begin
            align_err <= 1'b1;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (WAIT_STATES=3 and 0 instances)
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int WS0 = 3;
    localparam int WS1 = 0;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0]        wb_in, mr_in, mw_in;
    logic [1:0][31:0]  alu_in, st_in;
    logic [1:0][3:0]   dest_in;
    logic [1:0]        frz;
    logic [1:0][15:0]  s_addr;
    logic [1:0][31:0]  s_wdata, s_rdata;
    logic [1:0]        s_we, s_rd;
    logic [1:0]        wb_o, mr_o, aerr;
    logic [1:0][31:0]  alu_o, mres_o;
    logic [1:0][3:0]   dest_o;
    logic [1:0]        active, tmo;
    logic              done;

    mem_access_ctrl #(.WAIT_STATES(WS0)) u_ws3 (
        .clk(clk), .rst(rst[0]), .WB_en_in(wb_in[0]), .MEM_R_EN_in(mr_in[0]),
        .MEM_W_EN_in(mw_in[0]), .ALU_result_in(alu_in[0]), .ST_val_in(st_in[0]),
        .Dest_in(dest_in[0]), .freeze(frz[0]), .sram_addr(s_addr[0]),
        .sram_wdata(s_wdata[0]), .sram_we(s_we[0]), .sram_rd(s_rd[0]),
        .sram_rdata(s_rdata[0]), .WB_en(wb_o[0]), .MEM_R_EN(mr_o[0]),
        .ALU_result(alu_o[0]), .MEM_result(mres_o[0]), .Dest(dest_o[0]),
        .align_err(aerr[0])
    );

    mem_access_ctrl #(.WAIT_STATES(WS1)) u_ws0 (
        .clk(clk), .rst(rst[1]), .WB_en_in(wb_in[1]), .MEM_R_EN_in(mr_in[1]),
        .MEM_W_EN_in(mw_in[1]), .ALU_result_in(alu_in[1]), .ST_val_in(st_in[1]),
        .Dest_in(dest_in[1]), .freeze(frz[1]), .sram_addr(s_addr[1]),
        .sram_wdata(s_wdata[1]), .sram_we(s_we[1]), .sram_rd(s_rd[1]),
        .sram_rdata(s_rdata[1]), .WB_en(wb_o[1]), .MEM_R_EN(mr_o[1]),
        .ALU_result(alu_o[1]), .MEM_result(mres_o[1]), .Dest(dest_o[1]),
        .align_err(aerr[1])
    );

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mres;
        logic [3:0]  dest;
        logic        aerr;
        int          run;
        int          we;
        int          rd;
        logic [15:0] addr;
        logic [31:0] wd;
    } item_t;

    item_t sb0[$];
    item_t sb1[$];

    // SRAM background pattern; word 2 is preset for the directed read.
    function automatic logic [31:0] bg_word(input logic [15:0] a);
        return (a == 16'd2) ? 32'h1234_5678 : ({a, ~a} ^ 32'h0F0F_0F0F);
    endfunction

    logic [31:0] sram0 [int];
    logic [31:0] sram1 [int];

    initial begin
        s_rdata = '0;
        forever begin
            @(posedge clk);
            if (s_we[0]) sram0[int'(s_addr[0])] = s_wdata[0];
            if (s_we[1]) sram1[int'(s_addr[1])] = s_wdata[1];
            @(negedge clk);
            s_rdata[0] = sram0.exists(int'(s_addr[0])) ? sram0[int'(s_addr[0])] : bg_word(s_addr[0]);
            s_rdata[1] = sram1.exists(int'(s_addr[1])) ? sram1[int'(s_addr[1])] : bg_word(s_addr[1]);
        end
    end

    // Reference model: memory image, last loaded word, sticky alignment flag.
    logic [31:0] rm0 [int];
    logic [31:0] rm1 [int];
    logic [31:0] m_hold [2];
    bit          m_sticky [2];

    function automatic logic [31:0] ref_read(input int k, input logic [15:0] a);
        if (k == 0) return rm0.exists(int'(a)) ? rm0[int'(a)] : bg_word(a);
        return rm1.exists(int'(a)) ? rm1[int'(a)] : bg_word(a);
    endfunction

    task automatic issue(input int k, input bit w, input bit r, input bit wb,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] dest);
        item_t       it;
        int          n;
        int          ws;
        logic [31:0] off;
        logic [15:0] a;
        bit          bad;
        @(posedge clk); #1;
        wb_in[k] = wb; mw_in[k] = w; mr_in[k] = r;
        alu_in[k] = alu; st_in[k] = st; dest_in[k] = dest; active[k] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!frz[k]) break;
            n++;
            if (n > 64) begin
                tmo[k] = 1'b1;
                return;
            end
        end
        ws  = (k == 0) ? WS0 : WS1;
        off = alu - BASE;
        a   = off[17:2];
        bad = ALIGN && (w || r) && (alu[1:0] != 2'b00);
        it.run = 0; it.we = 0; it.rd = 0; it.addr = a; it.wd = st;
        if (bad) begin
            m_hold[k] = 32'd0;
            m_sticky[k] = 1'b1;
            it.run = 1;
        end else if (w) begin
            if (k == 0) rm0[int'(a)] = st; else rm1[int'(a)] = st;
            it.run = ws + 2;
            it.we = ws + 1;
        end else if (r) begin
            m_hold[k] = ref_read(k, a);
            it.run = ws + 2;
            it.rd = ws + 1;
        end
        it.wb = wb; it.mr = r; it.alu = alu; it.dest = dest;
        it.mres = m_hold[k]; it.aerr = m_sticky[k];
        if (k == 0) sb0.push_back(it); else sb1.push_back(it);
    endtask

    task automatic nop(input int k);
        wb_in[k] = 0; mw_in[k] = 0; mr_in[k] = 0; alu_in[k] = 0; st_in[k] = 0; dest_in[k] = 0;
    endtask

    task automatic finish_run(input int k);
        @(posedge clk); #1;
        active[k] = 1'b0;
        nop(k);
    endtask

    // Read aborted by reset in its second ACCESS cycle.
    task automatic reset_abort(input int k);
        @(posedge clk); #1;
        wb_in[k] = 1; mr_in[k] = 1; mw_in[k] = 0; alu_in[k] = BASE + 32'd28;
        dest_in[k] = 4'd9; active[k] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[k] = 1'b1; active[k] = 1'b0; nop(k);
        @(posedge clk); #1;
        rst[k] = 1'b0;
        m_hold[k] = 32'd0;
        m_sticky[k] = 1'b0;
    endtask

    task automatic random_ops(input int k, input int count);
        for (int i = 0; i < count; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = BASE + 32'(4 * $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = 32'($urandom_range(0, 255) * 4);
            issue(k, kind >= 2, kind == 1 || kind == 3, 1'($urandom_range(0, 1)),
                  a, $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic run0();
        issue(0, 0, 1, 1, 32'd1032, 32'd0, 4'd5);
        issue(0, 1, 0, 0, 32'd1032, 32'hDEAD_BEEF, 4'd0);
        issue(0, 0, 1, 1, 32'd1032, 32'd0, 4'd6);
        issue(0, 1, 1, 1, 32'd1036, 32'hCAFE_F00D, 4'd1);
        issue(0, 0, 1, 1, 32'd1036, 32'd0, 4'd2);
        reset_abort(0);
        issue(0, 0, 0, 1, 32'h0000_7777, 32'd0, 4'd4);
        issue(0, 0, 1, 1, 32'd1060, 32'd0, 4'd8);
        random_ops(0, 40);
        finish_run(0);
    endtask

    task automatic run1();
        issue(1, 0, 0, 1, 32'h0000_ABCD, 32'd0, 4'd3);
        issue(1, 0, 1, 1, 32'd1040, 32'd0, 4'd7);
        issue(1, 0, 1, 1, 32'd1044, 32'd0, 4'd8);
        issue(1, 1, 0, 0, 32'd1040, 32'h5555_AAAA, 4'd0);
        issue(1, 0, 1, 1, 32'd1040, 32'd0, 4'd9);
        issue(1, 0, 1, 1, 32'd1026, 32'd0, 4'd2);
        issue(1, 0, 0, 1, 32'h0000_1234, 32'd0, 4'd11);
        issue(1, 0, 1, 1, 32'd1032, 32'd0, 4'd12);
        random_ops(1, 40);
        finish_run(1);
    endtask

    initial begin
        rst = 2'b11; wb_in = '0; mr_in = '0; mw_in = '0; alu_in = '0; st_in = '0; dest_in = '0;
        active = '0; tmo = '0; done = 1'b0;
        m_hold[0] = 0; m_hold[1] = 0; m_sticky[0] = 0; m_sticky[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        fork
            run0();
            run1();
        join
        repeat (6) @(posedge clk);
        done = 1'b1;
    end

    int vec;
    int mis;

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h at %0t", k, nm, act, exp, $time);
        end
    endtask

    item_t       lastx [2];
    bit          last_ok [2], prev_acc [2], prev_frz [2], prev_rst [2];
    int          run [2], wec [2], rdc [2], a_run [2], a_we [2], a_rd [2];
    logic [15:0] cur_addr [2], a_addr [2];
    logic [31:0] cur_wd [2], a_wd [2];

    initial begin
        item_t it;
        vec = 0;
        mis = 0;
        for (int k = 0; k < 2; k++) begin
            last_ok[k] = 0; prev_acc[k] = 0; prev_frz[k] = 0; prev_rst[k] = 0;
            run[k] = 0; wec[k] = 0; rdc[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (prev_rst[k]) begin
                    chk(k, "rst_WB_en", 32'(wb_o[k]), 0);
                    chk(k, "rst_MEM_R_EN", 32'(mr_o[k]), 0);
                    chk(k, "rst_ALU_result", alu_o[k], 0);
                    chk(k, "rst_MEM_result", mres_o[k], 0);
                    chk(k, "rst_Dest", 32'(dest_o[k]), 0);
                    chk(k, "rst_align_err", 32'(aerr[k]), 0);
                    lastx[k].alu = 0; lastx[k].mres = 0; lastx[k].dest = 0;
                    last_ok[k] = 1;
                end else if (prev_acc[k]) begin
                    if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                        chk(k, "unexpected_output", 1, 0);
                    end else begin
                        it = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk(k, "WB_en", 32'(wb_o[k]), 32'(it.wb));
                        chk(k, "MEM_R_EN", 32'(mr_o[k]), 32'(it.mr));
                        chk(k, "ALU_result", alu_o[k], it.alu);
                        chk(k, "MEM_result", mres_o[k], it.mres);
                        chk(k, "Dest", 32'(dest_o[k]), 32'(it.dest));
                        chk(k, "align_err", 32'(aerr[k]), 32'(it.aerr));
                        chk(k, "freeze_cycles", a_run[k], it.run);
                        chk(k, "we_cycles", a_we[k], it.we);
                        chk(k, "rd_cycles", a_rd[k], it.rd);
                        if (it.we + it.rd > 0) chk(k, "sram_addr", 32'(a_addr[k]), 32'(it.addr));
                        if (it.we > 0) chk(k, "sram_wdata", a_wd[k], it.wd);
                        lastx[k] = it;
                        last_ok[k] = 1;
                    end
                end else if (prev_frz[k] && last_ok[k]) begin
                    chk(k, "bubble_WB_en", 32'(wb_o[k]), 0);
                    chk(k, "hold_ALU_result", alu_o[k], lastx[k].alu);
                    chk(k, "hold_MEM_result", mres_o[k], lastx[k].mres);
                    chk(k, "hold_Dest", 32'(dest_o[k]), 32'(lastx[k].dest));
                end
                if (rst[k]) chk(k, "rst_strobes", 32'({s_we[k], s_rd[k]}), 0);

                prev_rst[k] = rst[k];
                if (rst[k]) begin
                    run[k] = 0; wec[k] = 0; rdc[k] = 0;
                    prev_acc[k] = 0; prev_frz[k] = 0;
                end else if (frz[k]) begin
                    run[k]++;
                    if (s_we[k]) wec[k]++;
                    if (s_rd[k]) rdc[k]++;
                    if (s_we[k] || s_rd[k]) begin
                        cur_addr[k] = s_addr[k];
                        cur_wd[k] = s_wdata[k];
                    end
                    prev_frz[k] = 1; prev_acc[k] = 0;
                end else begin
                    a_run[k] = run[k]; a_we[k] = wec[k]; a_rd[k] = rdc[k];
                    a_addr[k] = cur_addr[k]; a_wd[k] = cur_wd[k];
                    run[k] = 0; wec[k] = 0; rdc[k] = 0;
                    prev_frz[k] = 0;
                    prev_acc[k] = active[k];
                    if (!active[k]) last_ok[k] = 0;
                end
            end
            if (done) begin
                chk(0, "timeout", 32'(tmo[0]), 0);
                chk(1, "timeout", 32'(tmo[1]), 0);
                chk(0, "leftover_expected", sb0.size(), 0);
                chk(1, "leftover_expected", sb1.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
                $finish;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 3, meaning extra SRAM access cycles beyond one (legal range 0..15).
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024, meaning the byte address that maps to SRAM word 0.
REQ-003 The block SHALL have parameter ADDR_W, default 16, meaning the SRAM word-address width.
REQ-004 The block SHALL have one clock and a synchronous active-high reset, with ports: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-005 The block SHALL have these EXE/MEM-register inputs: WB_en_in in 1; MEM_R_EN_in in 1; MEM_W_EN_in in 1; ALU_result_in in 32; ST_val_in in 32; Dest_in in 4.
REQ-006 The block SHALL have port freeze, out, 1 bit: stall to the upstream pipeline registers, active high.
REQ-007 The block SHALL have these SRAM ports: sram_addr out ADDR_W; sram_wdata out 32; sram_we out 1; sram_rd out 1; sram_rdata in 32.
REQ-008 The block SHALL have these MEM/WB outputs: WB_en out 1; MEM_R_EN out 1; ALU_result out 32; MEM_result out 32; Dest out 4.
REQ-009 The block SHALL have port align_err, out, 1 bit: sticky misaligned-access flag, described in Configuration.

Function
REQ-010 The FSM SHALL have three states, IDLE, ACCESS and DONE, and SHALL reset to IDLE.
REQ-011 A request SHALL be MEM_R_EN_in|MEM_W_EN_in; if both are high, the access SHALL be a write and the read SHALL be ignored.
REQ-012 In IDLE with a request, the FSM SHALL go to ACCESS and load wait counter cnt with WAIT_STATES; with no request it SHALL stay in IDLE.
REQ-013 In ACCESS, sram_we or sram_rd SHALL be high and the counter SHALL decrement; when cnt==0 the FSM SHALL go to DONE.
REQ-014 The ACCESS state SHALL therefore last exactly WAIT_STATES+1 cycles.
REQ-015 DONE SHALL last exactly one cycle and SHALL then return to IDLE.
REQ-016 On the edge that leaves the last ACCESS cycle, a read SHALL capture sram_rdata into an internal hold register.
REQ-017 freeze SHALL be combinational: 1 in ACCESS, 1 in IDLE while a request is present, and 0 in DONE.
REQ-018 A memory operation SHALL therefore hold freeze high for WAIT_STATES+2 consecutive cycles.
REQ-019 Freeze SHALL be low in DONE, so the upstream register advances once and the same instruction is never re-issued.
REQ-020 sram_addr SHALL equal (ALU_result_in - BASE_ADDR) >> 2, truncated to ADDR_W bits, with modulo wrap below BASE_ADDR.
REQ-021 sram_wdata SHALL equal ST_val_in.
REQ-022 sram_addr and sram_wdata SHALL be held stable throughout ACCESS.
REQ-023 The MEM/WB outputs SHALL be registered.
REQ-024 When freeze==0, the MEM/WB outputs SHALL load from the inputs, and MEM_result SHALL load the hold register.
REQ-025 When freeze==1, WB_en SHALL load 0 (bubble) and all other MEM/WB outputs SHALL hold.
REQ-026 A non-memory instruction in IDLE SHALL pass to the outputs with 1-cycle latency and no freeze.
REQ-027 Back-to-back memory instructions SHALL each incur the full WAIT_STATES+2 stall, with IDLE in between.

Reset
REQ-028 When rst is high at a clock edge, the FSM SHALL go to IDLE, cnt and the hold register SHALL clear to 0, and all registered outputs (WB_en, MEM_R_EN, ALU_result, MEM_result, Dest, align_err) SHALL clear to 0.
REQ-029 During rst, sram_we and sram_rd SHALL be 0.
REQ-030 A reset in ACCESS SHALL abort the access: strobes drop on the next cycle and no MEM/WB update occurs.
REQ-031 After reset, freeze SHALL follow the REQ-017 rule for IDLE.

Configuration
REQ-032 Macro MEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-033 With MEM_ALIGN_CHECK_EN defined, a request with ALU_result_in[1:0]!=0 SHALL skip ACCESS (IDLE->DONE), assert no SRAM strobe, pass MEM_result=0, and set align_err until rst.
REQ-034 Without MEM_ALIGN_CHECK_EN, align_err SHALL be tied 0 and low address bits SHALL be ignored.

Verification
REQ-035 The bench SHALL cover: WAIT_STATES=3, MEM_W_EN_in=1, ALU_result_in=1032, ST_val_in=0xDEADBEEF -> sram_addr=2, sram_we high 4 cycles, freeze high 5 cycles, WB_en=0 after.
REQ-036 The bench SHALL cover: read of 1032 with sram_rdata=0x12345678, WB_en_in=1, Dest_in=5 -> MEM_result=0x12345678, WB_en=1, Dest=5 one cycle after DONE.
REQ-037 The bench SHALL cover: WAIT_STATES=0, ALU op with no request, then a read -> ALU op output next cycle with no freeze; read freeze high exactly 2 cycles.
REQ-038 The bench SHALL cover: MEM_R_EN_in=MEM_W_EN_in=1 -> sram_we=1 and sram_rd=0 for the whole access.
REQ-039 The bench SHALL cover: rst asserted in 2nd ACCESS cycle -> next cycle IDLE, strobes 0, all outputs 0.
REQ-040 The bench SHALL cover, with MEM_ALIGN_CHECK_EN defined: read of 1026 -> no strobes, align_err=1 and sticky, freeze high 1 cycle.
